// File: rtl/palindrome_scanner_if.sv
// palindrome_scanner_if: serial bit stream, window config and result signals of the palindrome scanner
interface palindrome_scanner_if #(
    parameter int MAX_BITS = 10,
    parameter int LEN_W    = $clog2(MAX_BITS + 1),
    parameter int CNT_W    = 8
);
    logic             in_valid;
    logic             in;
    logic [LEN_W-1:0] len;
    logic             framed;
    logic             match;
    logic             evaluated;
    logic             full;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid, in, len, framed,
        input  match, evaluated, full, match_count
    );

    modport slave (
        input  in_valid, in, len, framed,
        output match, evaluated, full, match_count
    );
endinterface

// File: rtl/palindrome_scanner.sv
// palindrome_scanner: checks whether the last len accepted serial bits form a palindrome,
// in sliding or framed windows, with a saturating match counter
module palindrome_scanner #(
    parameter int MAX_BITS = 10,
    parameter int LEN_W    = $clog2(MAX_BITS + 1),
    parameter int CNT_W    = 8
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 clr,
    palindrome_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, SCAN} state_t;

    state_t              st;
    logic [MAX_BITS-1:0] sr;
    logic [LEN_W-1:0]    fill;
    logic [LEN_W-1:0]    len_q;
    logic                framed_q;
    logic                match_r;
    logic                evaluated_r;
    logic                full_r;
    logic [CNT_W-1:0]    count_r;
    logic [MAX_BITS-1:0] sr_n;
    logic [LEN_W-1:0]    len_c;
    logic [LEN_W-1:0]    fill_n;
    logic                pal;
    logic                done;

    assign sr_n   = {sr[MAX_BITS-2:0], bus.in};
    assign len_c  = bus.len < LEN_W'(2) ? LEN_W'(2) : bus.len > LEN_W'(MAX_BITS) ? LEN_W'(MAX_BITS) : bus.len;
    assign fill_n = fill + LEN_W'(1);
    assign done   = fill_n == len_q;

    // Mirror check over the post-shift window; bits at or above len_q never participate
    always_comb begin
        pal = 1'b1;
        for (int i = 0; i < MAX_BITS / 2; i++)
            if (i < int'(len_q) / 2 && sr_n[i] != sr_n[int'(len_q) - 1 - i])
                pal = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            sr          <= '0;
            fill        <= '0;
            len_q       <= LEN_W'(2);
            framed_q    <= 1'b0;
            match_r     <= 1'b0;
            evaluated_r <= 1'b0;
            full_r      <= 1'b0;
            count_r     <= '0;
        end else if (clr) begin
            st          <= IDLE;
            sr          <= '0;
            fill        <= '0;
            match_r     <= 1'b0;
            evaluated_r <= 1'b0;
            full_r      <= 1'b0;
            count_r     <= '0;
        end else begin
            match_r     <= 1'b0;
            evaluated_r <= 1'b0;
            full_r      <= st == SCAN;
            if (bus.in_valid) begin
                sr <= sr_n;
                case (st)
                    IDLE: begin
                        len_q    <= len_c;
                        framed_q <= bus.framed;
                        fill     <= LEN_W'(1);
                        full_r   <= 1'b0;
                        st       <= FILL;
                    end
                    FILL: begin
                        fill <= fill_n;
                        if (done) begin
                            evaluated_r <= 1'b1;
                            match_r     <= pal;
                            full_r      <= 1'b1;
                            count_r     <= pal && !(&count_r) ? count_r + CNT_W'(1) : count_r;
                            st          <= framed_q ? IDLE : SCAN;
                            fill        <= framed_q ? '0 : fill_n;
                        end
                    end
                    default: begin
                        evaluated_r <= 1'b1;
                        match_r     <= pal;
                        full_r      <= 1'b1;
                        count_r     <= pal && !(&count_r) ? count_r + CNT_W'(1) : count_r;
                    end
                endcase
            end
        end
    end

    assign bus.match       = match_r;
    assign bus.evaluated   = evaluated_r;
    assign bus.full        = full_r;
    assign bus.match_count = count_r;
endmodule

// File: doc/palindrome_scanner.md
Name: palindrome_scanner

Overview:
Parametrised successor to the fixed-width serial palindrome detector. It accepts one qualified serial bit per clock and checks whether the most recent window of len bits reads the same forwards and backwards. The window length is set at runtime, up to MAX_BITS. It supports sliding (overlapping) and framed (disjoint) windows and keeps a saturating match counter. It sits on a serial bit stream behind a framer or deserialiser.

Parameters:
MAX_BITS, 10, maximum window length (>=2); shift register depth.
LEN_W, $clog2(MAX_BITS+1), width of the len port.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; clears all state immediately.
clr  input  1  synchronous clear of window, FSM and counter; config is not latched.
in_valid  input  1  qualifies in; a bit is accepted on a rising edge with in_valid=1.
in  input  1  serial data bit.
len  input  LEN_W  requested window length; latched at window start.
framed  input  1  0=sliding windows, 1=disjoint windows; latched with len.
match  output  1  one-cycle pulse: the window just evaluated is a palindrome.
evaluated  output  1  one-cycle pulse: a window was evaluated (match or not).
full  output  1  window holds len_q valid bits (FSM in SCAN).
match_count  output  CNT_W  number of matches since reset/clr; saturates at all-ones.

Behaviour:
- Reset (reset=0, async): shift register=0, fill=0, len_q=2, framed_q=0, FSM=IDLE; match, evaluated, full and match_count all 0.
- Shift register: newest accepted bit enters at sr[0], older bits move up. The window is sr[len_q-1:0].
- Palindrome rule: sr[i]==sr[len_q-1-i] for all i<len_q/2. Bits above len_q are ignored.
- Clamp on latch: len<2 becomes 2; len>MAX_BITS becomes MAX_BITS.
- FSM states:
  - IDLE: fill=0. On an accepted bit: latch len_q and framed_q (clamped), shift the bit in, fill=1, go to FILL.
  - FILL: each accepted bit shifts in and increments fill. When the accepted bit makes fill==len_q, the window is evaluated on that edge.
    - framed_q=1: return to IDLE (fill=0). The next bit starts a disjoint window and relatches config.
    - framed_q=0: go to SCAN.
  - SCAN (sliding only): every accepted bit shifts in and evaluates the new window. Stays in SCAN until clr or reset.
- Timing: match and evaluated are registered. They are computed from the post-shift window on the accepting edge, so they are high for exactly the one cycle after that edge and low otherwise.
- match_count: increments on the same edge that sets match; holds at 2^CNT_W-1.
- full: 1 while in SCAN. In framed mode it pulses for the one cycle after each completing bit.
- in_valid=0: no shift, no state change; pulses drop to 0. Gaps between accepted bits are allowed and do not affect results.
- len/framed changes while in FILL or SCAN: ignored until the FSM next passes through IDLE.
- clr=1: go to IDLE, fill=0, shift register=0, match_count=0, pulses=0. If clr and in_valid are both high, clr wins and the bit is discarded.
- Reset asserted mid-window: all state and outputs clear asynchronously, without waiting for a clock edge. The first bit accepted after release starts a new window.

Test Plan:
1. Sliding, len=5, framed=0, in_valid=1, stream 1,1,0,1,1,0,1,1 -> evaluated pulses after bits 5,6,7,8; match pulses after bits 5 and 8 only; match_count=2; full=1 from bit 5 on.
2. Framed, len=4, framed=1, stream 1,0,0,1, 0,1,1,0, 1,1,0,0 -> evaluated after bits 4,8,12; match after 4 and 8; match_count=2; FSM in IDLE at end.
3. Repeat scenario 1 with in_valid low for 1-3 cycles between bits, including a gap between bits 5 and 6 -> identical pulse sequence in accepted-bit order; no pulse during gaps.
4. Clamp and latch: len=1, stream 1,1 -> match after bit 2. len=15 with MAX_BITS=10 -> first evaluation after bit 10. Change len from 5 to 3 mid-FILL -> window still completes at 5 bits.
5. Saturation: CNT_W=2, len=2, sliding, stream of 6 ones -> 5 match pulses; match_count goes 1,2,3,3,3.
6. Reset/clr: assert reset low after 3 bits of a len=5 window -> all outputs 0 before the next edge; after release, 5 further bits 1,0,0,0,1 -> match. clr and in_valid high together -> bit dropped, match_count=0, FSM IDLE.
